display_message_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one scrolling ASCII display between several message producers. Each producer presents an 80-bit packed ASCII string and a scroll flag. The block grants one producer at a time and captures its message. It then emits a one-cycle latch pulse to the downstream scrolling display, holds the message for a fixed dwell period, and acknowledges the producer. It sits between the application sources (counters, status, error text) and the scrolling display's string/scroll/latch inputs.

---
 rtl/display_message_arbiter.sv | 163 ++++++++++++++++
 tb/tb_display_message_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_message_arbiter.sv
// -----------------------------------------------------------------------------
// display_message_arbiter
//
// Shares one scrolling ASCII display between NUM_REQ message producers.
// An idle arbiter grants one requester by round-robin and captures its string
// and scroll flag. It pulses out_latch for one cycle so the display loads the
// message, then holds for a dwell period and pulses ack to the grantee.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   req         level request, one bit per requester
//   req_string  packed strings, requester i at [(i+1)*BUF_BITS-1 -: BUF_BITS]
//   req_scroll  per-requester "message needs scrolling" flag
//   ack         one-cycle pulse on the grantee's bit when its dwell completes
//   out_string  captured string (held until the next grant)
//   out_scroll  captured scroll flag (held until the next grant)
//   out_latch   one-cycle load strobe for the display
//   busy        high whenever a service is in progress
//   grant_id    index of the current or most recent grantee
// -----------------------------------------------------------------------------
module display_message_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int ID_BITS             = 2,
    parameter int BUF_BITS            = 80,
    parameter int DWELL_CYCLES        = 50_000_000,
    parameter int SCROLL_DWELL_CYCLES = 300_000_000,
    parameter int CNT_BITS            = 29
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*BUF_BITS-1:0] req_string,
    input  logic [NUM_REQ-1:0]          req_scroll,
    output logic [NUM_REQ-1:0]          ack,
    output logic [BUF_BITS-1:0]         out_string,
    output logic                        out_scroll,
    output logic                        out_latch,
    output logic                        busy,
    output logic [ID_BITS-1:0]          grant_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ID_BITS-1:0]  LAST_ID      = ID_BITS'(NUM_REQ - 1);
    localparam logic [CNT_BITS-1:0] DWELL_LOAD   = CNT_BITS'(DWELL_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SCROLL_LOAD  = CNT_BITS'(SCROLL_DWELL_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [BUF_BITS-1:0]   string_q, string_d;
    logic                  scroll_q, scroll_d;
    logic [ID_BITS-1:0]    grant_q, grant_d;
    logic [ID_BITS-1:0]    last_grant_q, last_grant_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  latch_q, latch_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;

    // Unpack the flat string bus into one word per requester.
    logic [BUF_BITS-1:0] req_str_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_str_arr[gi] = req_string[(gi+1)*BUF_BITS-1 -: BUF_BITS];
        end
    endgenerate

    // Round-robin pick: walk upward from last_grant+1, wrapping at NUM_REQ-1,
    // so the most recent grantee is always the last candidate considered.
    logic               sel_found;
    logic [ID_BITS-1:0] sel_id;
    logic [ID_BITS-1:0] scan_id;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_id   = last_grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = (scan_id == LAST_ID) ? '0 : scan_id + 1'b1;
            if (!sel_found && req[scan_id]) begin
                sel_found = 1'b1;
                sel_id    = scan_id;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        string_d     = string_q;
        scroll_d     = scroll_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        latch_d      = 1'b0;
        ack_d        = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    // Inputs are sampled only here; later changes are ignored.
                    string_d     = req_str_arr[sel_id];
                    scroll_d     = req_scroll[sel_id];
                    grant_d      = sel_id;
                    last_grant_d = sel_id;
                    latch_d      = 1'b1;
                    state_d      = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Loading D-1 and counting down to 0 gives exactly D DWELL cycles.
                cnt_d   = scroll_q ? SCROLL_LOAD : DWELL_LOAD;
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            string_q     <= '0;
            scroll_q     <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= LAST_ID;
            cnt_q        <= '0;
            latch_q      <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            string_q     <= string_d;
            scroll_q     <= scroll_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            ack_q        <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign out_string = string_q;
    assign out_scroll = scroll_q;
    assign out_latch  = latch_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_display_message_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for display_message_arbiter (NUM_REQ=4, dwell 4 / scroll dwell 10).
// A stimulus process drives requests and, from the arbitration rules, predicts
// each service (grant edge, string, scroll, ack edge) into queues. A separate
// monitor compares the DUT's outputs every cycle against those predictions.
// -----------------------------------------------------------------------------
module tb_display_message_arbiter;

    localparam int NR  = 4;
    localparam int BB  = 80;
    localparam int DW  = 4;
    localparam int SDW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*BB-1:0]  req_string;
    logic [NR-1:0]     req_scroll;
    logic [NR-1:0]     ack;
    logic [BB-1:0]     out_string;
    logic              out_scroll;
    logic              out_latch;
    logic              busy;
    logic [1:0]        grant_id;

    display_message_arbiter #(
        .NUM_REQ(NR), .ID_BITS(2), .BUF_BITS(BB),
        .DWELL_CYCLES(DW), .SCROLL_DWELL_CYCLES(SDW), .CNT_BITS(29)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_string(req_string),
        .req_scroll(req_scroll), .ack(ack), .out_string(out_string),
        .out_scroll(out_scroll), .out_latch(out_latch), .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          id;
        logic [79:0] str;
        logic        scr;
        int          edge_n;
    } rec_t;

    rec_t exp_latch[$];
    rec_t exp_ack[$];
    int   rst_q[$];

    // Reference model state (service-level view of the arbiter).
    int model_last = NR - 1;
    int free_edge  = 0;
    int busy_lo    = 1;
    int busy_hi    = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Called just after edge e-1; sets inputs for edge e and predicts the outcome.
    task automatic drive(input logic rst_v, input logic [NR-1:0] req_v);
        int   e;
        int   w;
        int   d;
        rec_t r;
        e = edge_cnt + 1;
        reset = rst_v;
        req   = req_v;
        if (rst_v) begin
            while (exp_ack.size() > 0 && exp_ack[$].edge_n >= e) void'(exp_ack.pop_back());
            if (busy_hi >= e) busy_hi = e - 1;
            rst_q.push_back(e);
            model_last = NR - 1;
            free_edge  = e + 1;
        end else if (e >= free_edge && req_v != 0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                if (w < 0 && req_v[(model_last + k) % NR]) w = (model_last + k) % NR;
            end
            d        = req_scroll[w] ? SDW : DW;
            r.id     = w;
            r.str    = req_string[w*BB +: BB];
            r.scr    = req_scroll[w];
            r.edge_n = e;
            exp_latch.push_back(r);
            r.edge_n = e + 1 + d;
            exp_ack.push_back(r);
            busy_lo    = e;
            busy_hi    = e + 1 + d;
            free_edge  = e + 3 + d;
            model_last = w;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    // Monitor: compares all outputs each cycle, on the falling edge.
    initial begin
        logic        started;
        logic [79:0] hold_str;
        logic        hold_scr;
        int          hold_id;
        logic [3:0]  ack_exp;
        rec_t        r;
        started  = 1'b0;
        hold_str = '0;
        hold_scr = 1'b0;
        hold_id  = 0;
        forever begin
            @(negedge clk);
            if (rst_q.size() > 0 && rst_q[0] == edge_cnt) begin
                void'(rst_q.pop_front());
                started  = 1'b1;
                hold_str = '0;
                hold_scr = 1'b0;
                hold_id  = 0;
            end
            if (started) begin
                if (exp_latch.size() > 0 && exp_latch[0].edge_n == edge_cnt) begin
                    r = exp_latch.pop_front();
                    chk("out_latch", 80'(out_latch), 80'(1));
                    hold_str = r.str;
                    hold_scr = r.scr;
                    hold_id  = r.id;
                end else begin
                    chk("out_latch", 80'(out_latch), 80'(0));
                end
                ack_exp = '0;
                if (exp_ack.size() > 0 && exp_ack[0].edge_n == edge_cnt) begin
                    r = exp_ack.pop_front();
                    ack_exp = 4'b0001 << r.id;
                end
                chk("ack", 80'(ack), 80'(ack_exp));
                chk("busy", 80'(busy), 80'(edge_cnt >= busy_lo && edge_cnt <= busy_hi));
                chk("grant_id", 80'(grant_id), 80'(hold_id));
                chk("out_string", out_string, hold_str);
                chk("out_scroll", 80'(out_scroll), 80'(hold_scr));
            end
        end
    end

    initial begin
        logic [79:0] hello;
        logic [95:0] rnd;
        logic [NR-1:0] rq;
        hello      = "HELLO     ";
        reset      = 1'b1;
        req        = '0;
        req_string = '0;
        req_scroll = '0;
        @(posedge clk);
        #2;
        drive(1'b1, '0);
        drive(1'b1, '0);

        // Single request, pulsed for one edge.
        idle(4);
        req_string[0 +: BB] = hello;
        drive(1'b0, 4'b0001);
        idle(10);

        // Round robin with all requesters held after reset.
        drive(1'b1, '0);
        for (int i = 0; i < 35; i++) drive(1'b0, 4'b1111);
        idle(10);

        // Scrolling message on requester 2.
        req_string[2*BB +: BB] = "SCROLLING!";
        req_scroll = 4'b0100;
        drive(1'b0, 4'b0100);
        idle(16);
        req_scroll = '0;

        // Requester 1 changes its string and drops req mid-dwell.
        req_string[1*BB +: BB] = "STATUS OK ";
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0010);
        req_string[1*BB +: BB] = "CHANGED!! ";
        idle(12);

        // Reset during requester 3's dwell; request stays high.
        req_string[3*BB +: BB] = "ERROR 42  ";
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b1000);
        drive(1'b1, 4'b1000);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b1000);
        idle(12);

        // Simultaneous requests 1 and 3 straight out of reset.
        drive(1'b1, 4'b1010);
        for (int i = 0; i < 14; i++) drive(1'b0, 4'b1010);
        idle(12);

        // Randomized traffic with changing strings and occasional reset.
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < NR; j++) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                req_string[j*BB +: BB] = rnd[79:0];
            end
            req_scroll = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 79) == 0, rq);
        end
        idle(20);

        n_cmp++;
        if (exp_latch.size() != 0 || exp_ack.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d latches and %0d acks still expected, required 0",
                     exp_latch.size(), exp_ack.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
